// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, S-box, round constants, GF(2^8) helpers
// and the single-step key expansion used by the iterative encryptor.
package aes_pkg;

  localparam int N_AES = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // One AES-128 key-schedule step: round key i -> round key i+1 using rcon[i+1].
  function automatic logic [N_AES-1:0] key_step(input logic [N_AES-1:0] key,
                                                input logic [7:0]       rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = key;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// last is set) and AddRoundKey. Byte i sits at bits 127-8i, column-major.
module aes_round
  import aes_pkg::*;
(
  input  logic [N_AES-1:0] state,
  input  logic [N_AES-1:0] round_key,
  input  logic             last,
  output logic [N_AES-1:0] next_state
);

  logic [7:0] sub_b   [16];
  logic [7:0] shift_b [16];
  logic [7:0] mix_b   [16];

  always_comb begin
    for (int i = 0; i < 16; i++) sub_b[i] = sbox(state[N_AES-1-8*i -: 8]);
  end

  // Byte index is 4*column + row; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shift_b[4*c + r] = sub_b[4*((c + r) % 4) + r];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mix_b[4*c + 0] = xtime(shift_b[4*c])      ^ gf_mul3(shift_b[4*c+1]) ^
                       shift_b[4*c+2]           ^ shift_b[4*c+3];
      mix_b[4*c + 1] = shift_b[4*c]             ^ xtime(shift_b[4*c+1])   ^
                       gf_mul3(shift_b[4*c+2])  ^ shift_b[4*c+3];
      mix_b[4*c + 2] = shift_b[4*c]             ^ shift_b[4*c+1]          ^
                       xtime(shift_b[4*c+2])    ^ gf_mul3(shift_b[4*c+3]);
      mix_b[4*c + 3] = gf_mul3(shift_b[4*c])    ^ shift_b[4*c+1]          ^
                       shift_b[4*c+2]           ^ xtime(shift_b[4*c+3]);
    end
  end

  always_comb begin
    // NOTE: default assignment first; a combinational block that leaves any
    // path unassigned infers a latch.
    next_state = '0;
    for (int i = 0; i < 16; i++)
      next_state[N_AES-1-8*i -: 8] = (last ? shift_b[i] : mix_b[i]) ^
                                     round_key[N_AES-1-8*i -: 8];
  end

endmodule

// File: rtl/aes_encr_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule,
// valid/ready handshake on both sides.
module aes_encr_iter
  import aes_pkg::*;
#(
  parameter int N  = N_AES,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] plaintext,
  input  logic [N-1:0] secret_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ciphertext,
  output logic         busy
);

  localparam logic [3:0] LAST_CNT = 4'(NR);

  state_e       fsm_q, fsm_d;
  logic [N-1:0] state_reg;
  logic [N-1:0] key_reg;
  logic [3:0]   round_cnt;
  logic [N-1:0] round_out;
  logic         last_round;
  logic         accept;

  assign last_round = (round_cnt == LAST_CNT);

  aes_round u_round (
    .state      (state_reg),
    .round_key  (key_reg),
    .last       (last_round),
    .next_state (round_out)
  );

  always_comb begin
    fsm_d  = fsm_q;
    accept = 1'b0;
    unique case (fsm_q)
      IDLE: if (in_valid && in_ready) begin
        accept = 1'b1;
        fsm_d  = RUN;
      end
      RUN:  if (last_round) fsm_d = DONE;
      DONE: if (out_valid && out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Handshake outputs are flops decoded from the next state, so they track the
  // state exactly and never depend combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is cleared with the FSM so an aborted job leaves no
      // plaintext or key material behind in the registers.
      fsm_q      <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      round_cnt  <= '0;
      ciphertext <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values of the others regardless of statement order.
      fsm_q     <= fsm_d;
      in_ready  <= (fsm_d == IDLE);
      out_valid <= (fsm_d == DONE);
      busy      <= (fsm_d == RUN);
      if (accept) begin
        state_reg <= plaintext ^ secret_key;
        key_reg   <= key_step(secret_key, rcon(4'd1));
        round_cnt <= 4'd1;
      end else if (fsm_q == RUN) begin
        state_reg <= round_out;
        round_cnt <= round_cnt + 4'd1;
        // The final round key is never needed, so rcon stays within 1..NR.
        if (!last_round) key_reg <= key_step(key_reg, rcon(round_cnt + 4'd1));
        if (last_round)  ciphertext <= round_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_encr_iter.sv
// Directed bench: FIPS-197 vectors on an NR=10 instance plus NR=5 and NR=1
// instances checked against a table-free reference model.
module tb_aes_encr_iter;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  // One round only: ShiftRows(SubBytes(round-1 input)) ^ round key 1.
  localparam logic [127:0] CT_B_NR1 = 128'h7445a32768e07e1f9be228c8344beee0;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] plaintext, secret_key;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] ciphertext [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] sb_tab [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_encr_iter #(.N(128), .NR((g == 0) ? 10 : (g == 1) ? 5 : 1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .plaintext  (plaintext),
      .secret_key (secret_key),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .ciphertext (ciphertext[g]),
      .busy       (busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse (a^254) and the affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] x = 8'h01;
    for (int i = 0; i < 254; i++) x = gmul(x, a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                               input int nr);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_tab[tmp[23:16]] ^ rc, sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) t[rr] = s[4*c+rr];
          for (int rr = 0; rr < 4; rr++)
            s[4*c+rr] = gmul(8'h02, t[rr]) ^ gmul(8'h03, t[(rr+1)%4]) ^ t[(rr+2)%4] ^ t[(rr+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_job(input int idx, input logic [127:0] pt, input logic [127:0] key,
                           output int acc_cyc);
    int guard = 0;
    plaintext     = pt;
    secret_key    = key;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 128'(in_ready[idx]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    acc_cyc       = cyc;
  endtask

  // lat = index of the first edge after the accept edge at which out_valid is 1.
  task automatic wait_done(input int idx, input bit toggle, output int lat,
                           output logic [127:0] ct);
    lat = 1;
    while (!out_valid[idx] && lat < 40) begin
      if (toggle) begin
        plaintext  = {$urandom, $urandom, $urandom, $urandom};
        secret_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    check("done_seen", 128'(out_valid[idx]), 128'd1);
    ct = ciphertext[idx];
  endtask

  initial begin
    int           acc1, acc2, lat;
    logic [127:0] ct;
    bit           late;

    for (int a = 0; a < 256; a++) sb_tab[a] = ref_sbox(8'(a));
    rst        = 1'b1;
    plaintext  = '0;
    secret_key = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  128'(in_ready[0]),  128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_busy",      128'(busy[0]),      128'd0);
    check("rst_ct",        ciphertext[0],      128'd0);
    check("rst_in_ready1", 128'(in_ready[2]),  128'd1);
    rst = 1'b0;

    // FIPS-197 C.1 vector, latency, run-state flags.
    start_job(0, PT_C1, KEY_C1, acc1);
    check("run_busy",     128'(busy[0]),     128'd1);
    check("run_in_ready", 128'(in_ready[0]), 128'd0);
    wait_done(0, 1'b0, lat, ct);
    check("c1_latency", 128'(lat), 128'd11);
    check("c1_ct",      ct,        CT_C1);

    // Back-to-back job: throughput NR+2, inputs scrambled during RUN, consumer stalls.
    start_job(0, PT_B, KEY_B, acc2);
    check("throughput", 128'(acc2 - acc1), 128'd12);
    out_ready[0] = 1'b0;
    wait_done(0, 1'b1, lat, ct);
    check("b_latency", 128'(lat), 128'd11);
    check("b_ct",      ct,        CT_B);

    plaintext   = PT_C1;
    secret_key  = KEY_C1;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_ct",        ciphertext[0],      CT_B);
      check("hold_in_ready",  128'(in_ready[0]),  128'd0);
      check("hold_out_valid", 128'(out_valid[0]), 128'd1);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("hs_out_valid", 128'(out_valid[0]), 128'd0);
    check("hs_in_ready",  128'(in_ready[0]),  128'd1);
    check("hs_busy",      128'(busy[0]),      128'd0);
    check("hs_ct_kept",   ciphertext[0],      CT_B);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("second_busy", 128'(busy[0]), 128'd1);
    wait_done(0, 1'b1, lat, ct);
    check("second_latency", 128'(lat), 128'd11);
    check("second_ct",      ct,        CT_C1);

    // Abort in round 4: reset wins, no late result.
    @(negedge clk);
    start_job(0, PT_B, KEY_B, acc1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_in_ready",  128'(in_ready[0]),  128'd1);
    check("abort_ct",        ciphertext[0],      128'd0);
    check("abort_busy",      128'(busy[0]),      128'd0);
    late = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) late = 1'b1;
    end
    check("abort_no_late", 128'(late), 128'd0);

    // Reset beats a simultaneous accept.
    in_valid[0] = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    check("rst_vs_accept_busy",  128'(busy[0]),     128'd0);
    check("rst_vs_accept_ready", 128'(in_ready[0]), 128'd1);

    // Truncated-round builds.
    start_job(1, PT_C1, KEY_C1, acc1);
    wait_done(1, 1'b0, lat, ct);
    check("nr5_latency", 128'(lat), 128'd6);
    check("nr5_ct",      ct,        ref_encrypt(PT_C1, KEY_C1, 5));
    @(negedge clk);
    start_job(2, PT_B, KEY_B, acc1);
    wait_done(2, 1'b1, lat, ct);
    check("nr1_latency",  128'(lat), 128'd2);
    check("nr1_ct",       ct,        CT_B_NR1);
    check("nr1_ct_model", ct,        ref_encrypt(PT_B, KEY_B, 1));
    @(negedge clk);
    start_job(1, PT_B, KEY_B, acc1);
    wait_done(1, 1'b1, lat, ct);
    check("nr5_ct_b", ct, ref_encrypt(PT_B, KEY_B, 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
